strip_y_map: RTL and testbench

STRIP_Y_MAP -- requirements
Module: strip_y_map

---
 rtl/strip_pkg.sv | 27 ++
 rtl/strip_y_builder.sv | 48 ++++
 rtl/strip_y_map.sv | 183 ++++++++++++++++++
 tb/tb_strip_y_map.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_pkg.sv
// Shared constants, state encoding and default strip heights for the strip y map.
package strip_pkg;

    localparam int unsigned DEF_N_STRIPS = 13;
    localparam int unsigned DEF_ID_W     = 4;
    localparam int unsigned DEF_H_W      = 5;
    localparam int unsigned DEF_Y_W      = 8;
    localparam int unsigned DEF_Y_MAX    = 128;

    // Power-on heights for strips 1..13
    localparam int unsigned DEF_HEIGHTS [13] = '{8, 8, 9, 7, 10, 6, 11, 5, 12, 4, 16, 16, 16};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Default height for a strip ID; IDs outside 1..13 default to 0
    function automatic int unsigned default_height(input int unsigned id);
        if (id >= 1 && id <= 13) begin
            return DEF_HEIGHTS[4'(id - 1)];
        end
        return 0;
    endfunction

endpackage

// File: rtl/strip_y_builder.sv
// Walks strips 1..N_STRIPS, accumulating heights into y bases and flagging overflow.
module strip_y_builder #(
    parameter int unsigned N_STRIPS = 13,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned H_W      = 5,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned Y_MAX    = 128
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [H_W-1:0]  i_h,
    output logic [ID_W-1:0] o_idx,
    output logic [Y_W:0]    o_acc,
    output logic            o_ovf_c,
    output logic            o_last_c
);

    localparam int unsigned ACC_W = Y_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ID_W-1:0]  r_idx;
    logic [ACC_W-1:0] r_acc;
    logic [SUM_W-1:0] w_sum;

    // One extra bit so saturation and the overflow compare see the true sum
    assign w_sum    = {1'b0, r_acc} + SUM_W'(i_h);
    assign o_ovf_c  = w_sum > SUM_W'(Y_MAX);
    assign o_last_c = r_idx == ID_W'(N_STRIPS);
    assign o_idx    = r_idx;
    assign o_acc    = r_acc;

    // Strip counter and saturating accumulator
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_idx <= ID_W'(1);
            r_acc <= '0;
        end else if (i_step) begin
            r_idx <= r_idx + ID_W'(1);
            r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/strip_y_map.sv
// Strip height/y-base tables with auto-build FSM and a registered lookup port.
module strip_y_map
    import strip_pkg::*;
#(
    parameter int unsigned N_STRIPS = DEF_N_STRIPS,
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned H_W      = DEF_H_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned Y_MAX    = DEF_Y_MAX
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cfg_we_i,
    input  logic [ID_W-1:0] cfg_id_i,
    input  logic [H_W-1:0]  cfg_h_i,
    input  logic            build_i,
    output logic            busy_o,
    output logic            table_ok_o,
    output logic            ovf_o,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [ID_W-1:0] req_id_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [Y_W-1:0]  resp_y_o,
    output logic            resp_err_o
);

    localparam int unsigned N_ENT = 1 << ID_W;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_boot;
    logic            r_busy;
    logic            r_table_ok;
    logic            r_ovf;
    logic            w_bld_start;
    logic            w_bld_step;
    logic            w_cfg_hit;
    logic            w_req_fire;
    logic            w_req_ok;
    logic [ID_W-1:0] w_bld_idx;
    logic [Y_W:0]    w_bld_acc;
    logic            w_bld_ovf;
    logic            w_bld_last;

    logic [H_W-1:0]   r_h [N_ENT];
    logic [Y_W-1:0]   r_y [N_ENT];
    logic [N_ENT-1:0] r_ovft;

    logic            r_resp_valid;
    logic [Y_W-1:0]  r_resp_y;
    logic            r_resp_err;

    assign w_cfg_hit  = cfg_we_i && (r_state != ST_BUILD) &&
                        (cfg_id_i != '0) && (cfg_id_i <= ID_W'(N_STRIPS));
    assign w_bld_step = r_state == ST_BUILD;

    strip_y_builder #(
        .N_STRIPS (N_STRIPS),
        .ID_W     (ID_W),
        .H_W      (H_W),
        .Y_W      (Y_W),
        .Y_MAX    (Y_MAX)
    ) u_builder (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_start  (w_bld_start),
        .i_step   (w_bld_step),
        .i_h      (r_h[w_bld_idx]),
        .o_idx    (w_bld_idx),
        .o_acc    (w_bld_acc),
        .o_ovf_c  (w_bld_ovf),
        .o_last_c (w_bld_last)
    );

    // Next-state: boot or build request starts a build; a cfg write invalidates READY
    always_comb begin
        w_state_nxt = r_state;
        w_bld_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_boot || build_i) begin
                    w_state_nxt = ST_BUILD;
                    w_bld_start = 1'b1;
                end
            end
            ST_BUILD: begin
                if (w_bld_last) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (build_i) begin
                    w_state_nxt = ST_BUILD;
                    w_bld_start = 1'b1;
                end else if (w_cfg_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered status flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_boot     <= 1'b1;
            r_busy     <= 1'b0;
            r_table_ok <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_state_nxt == ST_BUILD;
            r_table_ok <= w_state_nxt == ST_READY;
            if (w_bld_start) begin
                r_boot <= 1'b0;
            end
        end
    end

    // Height table: defaults at reset, cfg writes outside BUILD
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < N_ENT; k++) begin
                r_h[k] <= (k >= 1 && k <= N_STRIPS) ? H_W'(default_height(k)) : '0;
            end
        end else if (w_cfg_hit) begin
            r_h[cfg_id_i] <= cfg_h_i;
        end
    end

    // y table and per-strip overflow bits filled one strip per BUILD cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < N_ENT; k++) begin
                r_y[k] <= '0;
            end
            r_ovft <= '0;
        end else if (w_bld_step) begin
            r_y[w_bld_idx]    <= Y_W'(w_bld_acc);
            r_ovft[w_bld_idx] <= w_bld_ovf;
        end
    end

    // Sticky overflow summary, cleared when a build starts
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_bld_start) begin
            r_ovf <= 1'b0;
        end else if (w_bld_step && w_bld_ovf) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_req_ok    = (req_id_i != '0) && (req_id_i <= ID_W'(N_STRIPS)) && !r_ovft[req_id_i];
    assign req_ready_o = r_table_ok && (!r_resp_valid || resp_ready_i);
    assign w_req_fire  = req_valid_i && req_ready_o;

    // One-deep response buffer; holds while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_resp_valid <= 1'b0;
            r_resp_y     <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_req_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_req_ok;
            r_resp_y     <= w_req_ok ? r_y[req_id_i] : '0;
        end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign busy_o       = r_busy;
    assign table_ok_o   = r_table_ok;
    assign ovf_o        = r_ovf;
    assign resp_valid_o = r_resp_valid;
    assign resp_y_o     = r_resp_y;
    assign resp_err_o   = r_resp_err;

endmodule

// File: tb/tb_strip_y_map.sv
// Randomized bench for strip_y_map against a table-level reference model.
module tb_strip_y_map;

    localparam int N       = 13;
    localparam int Y_MAX   = 128;
    localparam int ACC_MAX = 511;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_id;
    logic [4:0] cfg_h;
    logic       build;
    logic       busy_o, table_ok_o, ovf_o;
    logic       req_valid, req_ready_o;
    logic [3:0] req_id;
    logic       resp_valid_o, resp_ready;
    logic [7:0] resp_y_o;
    logic       resp_err_o;

    always #5 clk = ~clk;

    strip_y_map dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_id_i     (cfg_id),
        .cfg_h_i      (cfg_h),
        .build_i      (build),
        .busy_o       (busy_o),
        .table_ok_o   (table_ok_o),
        .ovf_o        (ovf_o),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready),
        .resp_y_o     (resp_y_o),
        .resp_err_o   (resp_err_o)
    );

    typedef struct {
        int y;
        bit err;
    } resp_t;

    int    def_h [13] = '{8, 8, 9, 7, 10, 6, 11, 5, 12, 4, 16, 16, 16};
    int    m_h   [16];
    int    m_y   [16];
    bit    m_ov  [16];
    bit    m_boot;
    bit    m_ready;
    bit    m_ovf_any;
    int    m_busy;
    resp_t q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            m_h[k]  = (k >= 1 && k <= N) ? def_h[k-1] : 0;
            m_y[k]  = 0;
            m_ov[k] = 1'b0;
        end
        m_boot    = 1'b1;
        m_busy    = 0;
        m_ready   = 1'b0;
        m_ovf_any = 1'b0;
        q.delete();
    endfunction

    // Prefix sums of heights with saturation; overflow where the strip ends past Y_MAX
    function automatic void model_build();
        int acc = 0;
        m_ovf_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            m_y[k]  = acc;
            m_ov[k] = (acc + m_h[k]) > Y_MAX;
            if (m_ov[k]) m_ovf_any = 1'b1;
            acc = acc + m_h[k];
            if (acc > ACC_MAX) acc = ACC_MAX;
        end
    endfunction

    function automatic resp_t model_lookup(input int rid);
        resp_t r;
        if (rid == 0 || rid > N || m_ov[rid]) begin
            r.y   = 0;
            r.err = 1'b1;
        end else begin
            r.y   = m_y[rid];
            r.err = 1'b0;
        end
        return r;
    endfunction

    // Advance the model across one rising edge using the inputs currently driven
    function automatic void model_step();
        bit hit;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_ready = 1'b1;
        end else begin
            hit = cfg_we && (cfg_id >= 1) && (cfg_id <= N);
            if (hit) m_h[cfg_id] = int'(cfg_h);
            if (build || m_boot) begin
                m_boot  = 1'b0;
                m_busy  = N;
                m_ready = 1'b0;
                model_build();
            end else if (hit) begin
                m_ready = 1'b0;
            end
        end
    endfunction

    // Drive one cycle, check outputs mid-cycle, then step the model over the edge
    task automatic cycle(input bit we, input int id, input int h, input bit bld,
                         input bit rv, input int rid, input bit rr);
        bit exp_rdy;
        cfg_we     = we;
        cfg_id     = 4'(id);
        cfg_h      = 5'(h);
        build      = bld;
        req_valid  = rv;
        req_id     = 4'(rid);
        resp_ready = rr;
        @(negedge clk);
        check("busy", busy_o, m_busy > 0);
        check("table_ok", table_ok_o, m_ready);
        if (m_busy == 0) check("ovf", ovf_o, m_ovf_any);
        exp_rdy = m_ready && (q.size() == 0 || rr);
        check("req_ready", req_ready_o, exp_rdy);
        check("resp_valid", resp_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("resp_y", resp_y_o, q[0].y);
            check("resp_err", resp_err_o, q[0].err);
            if (rr) void'(q.pop_front());
        end
        if (rv && exp_rdy) q.push_back(model_lookup(rid));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic lookup(input int rid);
        cycle(0, 0, 0, 0, 1, rid, 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !m_ready; i++) idle();
    endtask

    // Assert reset mid-cycle, check outputs drop at once, release on a falling edge
    task automatic do_reset();
        cfg_we = 0; cfg_id = 0; cfg_h = 0; build = 0;
        req_valid = 0; req_id = 0; resp_ready = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_table_ok", table_ok_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_y", resp_y_o, 0);
        check("rst_resp_err", resp_err_o, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        cfg_we = 0; cfg_id = 0; cfg_h = 0; build = 0;
        req_valid = 0; req_id = 0; resp_ready = 1;
        @(posedge clk);
        #1;
        do_reset();
        wait_ready();

        // Default table lookups, then invalid IDs followed by a valid one
        lookup(1); lookup(4); lookup(8); lookup(12); lookup(13);
        lookup(0); lookup(14); lookup(5);
        idle(); idle();

        // Back-pressure: one accepted, three stalled cycles, then drain
        cycle(0, 0, 0, 0, 1, 2, 0);
        repeat (3) cycle(0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 1, 3, 1);
        idle();

        // Random lookups with random consumer stalls
        for (int i = 0; i < 80; i++) begin
            cycle(0, 0, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0);
        end
        idle(); idle();

        // h[1]=20 pushes strip 13 past the array height
        cycle(1, 1, 20, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        wait_ready();
        lookup(2); lookup(12); lookup(13);
        idle();

        // cfg write in READY with a response pending, then rebuild
        cycle(1, 5, 7, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 1, 3, 1);
        repeat (3) cycle(0, 0, 0, 0, 1, 4, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        wait_ready();
        lookup(5); lookup(6);
        idle();

        // Random mix of writes, build requests and lookups
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 31),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 0, 1, 0, 0, 1);
        wait_ready();

        // Reset during the sixth build cycle, then the default table must return
        cycle(0, 0, 0, 1, 1, 2, 1);
        repeat (5) idle();
        do_reset();
        wait_ready();
        lookup(1); lookup(4); lookup(8); lookup(12); lookup(13);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
